// File: rtl/pmod_link_channels.sv
// rtl/pmod_link_channels.sv - PMOD inter-board link: registered tx pins, synchronised/filtered/edge-detected rx pins
//
// Purpose:
//   Drives CHANNELS local control bits onto registered header pins and receives
//   CHANNELS remote bits. Each rx wire goes through a SYNC_STAGES synchroniser,
//   then a glitch filter that accepts a change only after FILTER_CYCLES stable
//   cycles, then an edge detector. A startup counter holds rx_valid low (and
//   masks edge pulses) until the rx path has had time to settle after reset.
//
// Configuration macro:
//   LINK_STICKY_EN  - when defined, rx_sticky latches rx_rise per channel until
//                     cleared by sticky_clr (set wins). When undefined, rx_sticky
//                     is tied to 0 and sticky_clr is ignored.
//
// Ports:
//   clk         in   1         system clock, all flops on rising edge
//   rst_n       in   1         asynchronous active-low reset
//   tx_data     in   CHANNELS  local bits to send
//   tx_pins     out  CHANNELS  registered copy of tx_data
//   rx_pins     in   CHANNELS  raw asynchronous remote wires
//   rx_data     out  CHANNELS  filtered remote levels
//   rx_rise     out  CHANNELS  1-cycle pulse on accepted 0->1 change
//   rx_fall     out  CHANNELS  1-cycle pulse on accepted 1->0 change
//   rx_valid    out  1         rx path settled since reset
//   sticky_clr  in   CHANNELS  per-channel clear of rx_sticky
//   rx_sticky   out  CHANNELS  latched rise events

module pmod_link_channels #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 65000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] tx_data,
  output logic [CHANNELS-1:0] tx_pins,
  input  logic [CHANNELS-1:0] rx_pins,
  output logic [CHANNELS-1:0] rx_data,
  output logic [CHANNELS-1:0] rx_rise,
  output logic [CHANNELS-1:0] rx_fall,
  output logic                rx_valid,
  input  logic [CHANNELS-1:0] sticky_clr,
  output logic [CHANNELS-1:0] rx_sticky
);

  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam int SCW = $clog2(SYNC_STAGES + FILTER_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILTER_CYCLES - 1);
  localparam logic [SCW-1:0] START_LAST = SCW'(SYNC_STAGES + FILTER_CYCLES - 1);

  typedef enum logic [0:0] {COUNTING = 1'b0, VALID = 1'b1} state_t;

  state_t   state_q, state_d;
  logic [SCW-1:0] start_cnt_q, start_cnt_d;

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CHANNELS-1:0][FCW-1:0]         filt_cnt;
  logic [CHANNELS-1:0]                  sync_s;
  logic [CHANNELS-1:0]                  accept;

  // TX path: plain register, no filtering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_pins <= '0;
    else        tx_pins <= tx_data;
  end

  // Per-channel synchroniser chain; bit 0 takes the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], rx_pins[i]};
    end
  end

  // A change is accepted on the cycle its counter has already seen
  // FILTER_CYCLES-1 disagreeing cycles, so the total hold is FILTER_CYCLES.
  always_comb begin
    sync_s = '0;
    accept = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_s[i] = sync_q[i][SYNC_STAGES-1];
      accept[i] = (sync_s[i] != rx_data[i]) && (filt_cnt[i] == FILT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      rx_data  <= '0;
      rx_rise  <= '0;
      rx_fall  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_s[i] == rx_data[i]) begin
          filt_cnt[i] <= '0;
        end else if (accept[i]) begin
          rx_data[i]  <= sync_s[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FCW'(1);
        end
      end
      // Edges are masked until settled so lines already high at power-up
      // do not look like presses.
      rx_rise <= accept &  sync_s & {CHANNELS{rx_valid}};
      rx_fall <= accept & ~sync_s & {CHANNELS{rx_valid}};
    end
  end

  // Startup sequencer: count to SYNC_STAGES+FILTER_CYCLES edges, then stay VALID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COUNTING;
      start_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    case (state_q)
      COUNTING: begin
        if (start_cnt_q == START_LAST) state_d = VALID;
        else                           start_cnt_d = start_cnt_q + SCW'(1);
      end
      VALID:   state_d = VALID;
      default: state_d = COUNTING;
    endcase
  end

  assign rx_valid = (state_q == VALID);

`ifdef LINK_STICKY_EN
  // Set comes from the registered rise pulse, so a clear issued in the same
  // cycle the game logic sees rx_rise loses to the new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sticky <= '0;
    else        rx_sticky <= rx_rise | (rx_sticky & ~sticky_clr);
  end
`else
  logic [CHANNELS-1:0] sticky_clr_unused;
  assign sticky_clr_unused = sticky_clr;
  assign rx_sticky         = '0;
`endif

endmodule

// File: tb/tb_pmod_link_channels.sv
// tb/tb_pmod_link_channels.sv - directed self-checking bench for pmod_link_channels
module tb_pmod_link_channels;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tx_data, tx_pins, rx_pins, rx_data, rx_rise, rx_fall;
  logic [3:0] sticky_clr, rx_sticky;
  logic       rx_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pmod_link_channels #(
    .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_pins(tx_pins),
    .rx_pins(rx_pins), .rx_data(rx_data), .rx_rise(rx_rise), .rx_fall(rx_fall),
    .rx_valid(rx_valid), .sticky_clr(sticky_clr), .rx_sticky(rx_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_d;
    logic       exp_v;
    rst_n = 1'b0; tx_data = 4'b0000; rx_pins = 4'b1111; sticky_clr = 4'b0000;
    tick(); tick();
    n_checks++;
    if ({tx_pins, rx_data, rx_rise, rx_fall, rx_valid, rx_sticky} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b required 0",
               {tx_pins, rx_data, rx_rise, rx_fall, rx_valid, rx_sticky});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_v = (e >= 6);
      exp_d = (e >= 6) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (rx_valid !== exp_v) begin
        n_errors++;
        $display("FAIL startup_valid edge %0d: got %b required %b", e, rx_valid, exp_v);
      end
      n_checks++;
      if (rx_data !== exp_d) begin
        n_errors++;
        $display("FAIL startup_data edge %0d: got %b required %b", e, rx_data, exp_d);
      end
      n_checks++;
      if (rx_rise !== 4'b0000 || rx_fall !== 4'b0000) begin
        n_errors++;
        $display("FAIL startup_edges edge %0d: rise %b fall %b required 0000", e, rx_rise, rx_fall);
      end
    end
  endtask

  task automatic test_tx();
    tx_data = 4'b1010;
    #1;
    n_checks++;
    if (tx_pins !== 4'b0000) begin
      n_errors++;
      $display("FAIL tx_before_edge: got %b required 0000", tx_pins);
    end
    tick();
    n_checks++;
    if (tx_pins !== 4'b1010) begin
      n_errors++;
      $display("FAIL tx_latency: got %b required 1010", tx_pins);
    end
    n_checks++;
    if (rx_data !== 4'b1111 || rx_rise !== 4'b0000 || rx_fall !== 4'b0000) begin
      n_errors++;
      $display("FAIL tx_rx_isolation: data %b rise %b fall %b required 1111 0000 0000",
               rx_data, rx_rise, rx_fall);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vec [5] = '{4'b0101, 4'b1100, 4'b0011, 4'b1111, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      tx_data = vec[k];
      tick();
      n_checks++;
      if (tx_pins !== vec[k]) begin
        n_errors++;
        $display("FAIL tx_b2b %0d: got %b required %b", k, tx_pins, vec[k]);
      end
    end
  endtask

  task automatic test_fall();
    logic [3:0] exp_d, exp_f;
    rx_pins = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_d = (e >= 6) ? 4'b0000 : 4'b1111;
      exp_f = (e == 6) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (rx_data !== exp_d || rx_fall !== exp_f || rx_rise !== 4'b0000) begin
        n_errors++;
        $display("FAIL fall_all edge %0d: data %b fall %b rise %b required %b %b 0000",
                 e, rx_data, rx_fall, rx_rise, exp_d, exp_f);
      end
    end
  endtask

  task automatic test_rise();
    logic [3:0] exp_d, exp_r, exp_s;
    rx_pins = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_d = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_r = (e == 6) ? 4'b0001 : 4'b0000;
`ifdef LINK_STICKY_EN
      exp_s = (e >= 7) ? 4'b0001 : 4'b0000;
`else
      exp_s = 4'b0000;
`endif
      n_checks++;
      if (rx_data !== exp_d || rx_rise !== exp_r || rx_fall !== 4'b0000) begin
        n_errors++;
        $display("FAIL rise_ch0 edge %0d: data %b rise %b fall %b required %b %b 0000",
                 e, rx_data, rx_rise, rx_fall, exp_d, exp_r);
      end
      n_checks++;
      if (rx_sticky !== exp_s) begin
        n_errors++;
        $display("FAIL rise_sticky edge %0d: got %b required %b", e, rx_sticky, exp_s);
      end
    end
  endtask

  task automatic test_glitch();
    rx_pins = 4'b0101;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 3) rx_pins = 4'b0001;
      n_checks++;
      if (rx_data !== 4'b0001 || rx_rise !== 4'b0000 || rx_fall !== 4'b0000) begin
        n_errors++;
        $display("FAIL glitch_ch2 edge %0d: data %b rise %b fall %b required 0001 0000 0000",
                 e, rx_data, rx_rise, rx_fall);
      end
    end
  endtask

  task automatic test_sticky();
`ifdef LINK_STICKY_EN
    sticky_clr = 4'b0001;
    tick();
    sticky_clr = 4'b0000;
    n_checks++;
    if (rx_sticky !== 4'b0000) begin
      n_errors++;
      $display("FAIL sticky_clr_ch0: got %b required 0000", rx_sticky);
    end
    rx_pins = 4'b0011;
    repeat (7) tick();
    n_checks++;
    if (rx_sticky !== 4'b0010) begin
      n_errors++;
      $display("FAIL sticky_set_ch1: got %b required 0010", rx_sticky);
    end
    rx_pins = 4'b0001;
    repeat (7) tick();
    n_checks++;
    if (rx_sticky !== 4'b0010 || rx_data !== 4'b0001) begin
      n_errors++;
      $display("FAIL sticky_hold_on_fall: sticky %b data %b required 0010 0001", rx_sticky, rx_data);
    end
    rx_pins = 4'b0011;
    repeat (6) tick();
    n_checks++;
    if (rx_rise !== 4'b0010 || rx_sticky !== 4'b0010) begin
      n_errors++;
      $display("FAIL sticky_second_rise: rise %b sticky %b required 0010 0010", rx_rise, rx_sticky);
    end
    sticky_clr = 4'b0010;
    tick();
    n_checks++;
    if (rx_sticky !== 4'b0010) begin
      n_errors++;
      $display("FAIL sticky_set_wins: got %b required 0010", rx_sticky);
    end
    tick();
    n_checks++;
    if (rx_sticky !== 4'b0000) begin
      n_errors++;
      $display("FAIL sticky_clr_alone: got %b required 0000", rx_sticky);
    end
    sticky_clr = 4'b0000;
`else
    sticky_clr = 4'b1111;
    rx_pins = 4'b0011;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_checks++;
      if (rx_sticky !== 4'b0000) begin
        n_errors++;
        $display("FAIL sticky_disabled edge %0d: got %b required 0000", e, rx_sticky);
      end
    end
    n_checks++;
    if (rx_data !== 4'b0011) begin
      n_errors++;
      $display("FAIL sticky_disabled_data: got %b required 0011", rx_data);
    end
    sticky_clr = 4'b0000;
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_d;
    tx_data = 4'b1001;
    rx_pins = 4'b1011;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_pins, rx_data, rx_rise, rx_fall, rx_valid, rx_sticky} !== 21'd0) begin
      n_errors++;
      $display("FAIL async_reset: got %b required 0",
               {tx_pins, rx_data, rx_rise, rx_fall, rx_valid, rx_sticky});
    end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_d = (e >= 6) ? 4'b1011 : 4'b0000;
      n_checks++;
      if (rx_valid !== (e >= 6) || rx_data !== exp_d) begin
        n_errors++;
        $display("FAIL restart edge %0d: valid %b data %b required %b %b",
                 e, rx_valid, rx_data, (e >= 6), exp_d);
      end
      n_checks++;
      if (rx_rise !== 4'b0000 || rx_fall !== 4'b0000 || tx_pins !== 4'b1001) begin
        n_errors++;
        $display("FAIL restart_misc edge %0d: rise %b fall %b tx %b required 0000 0000 1001",
                 e, rx_rise, rx_fall, tx_pins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_fall();
    test_rise();
    test_glitch();
    test_sticky();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
